// File: rtl/gram_write_arbiter_if.sv
// rtl/gram_write_arbiter_if.sv - requester-side req/ack bundle for the GRAM write arbiter
interface gram_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;

    modport master (output req, output req_addr, output req_data, input ack);
    modport slave  (input req, input req_addr, input req_data, output ack);
endinterface

// File: rtl/gram_write_arbiter.sv
// rtl/gram_write_arbiter.sv - round-robin vblank-gated GRAM write arbiter with per-frame budget
module gram_write_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int FRAME_BUDGET = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vblank,
    gram_write_arbiter_if.slave  rq,
    output logic [31:0]          bram_addr,
    output logic [31:0]          bram_wdata,
    output logic [3:0]           bram_we,
    output logic                 bram_en,
    output logic                 busy,
    output logic                 budget_hit
);
    localparam int CNT_W = $clog2(FRAME_BUDGET + 1);
    localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] BUDGET = CNT_W'(FRAME_BUDGET);

    typedef enum logic [1:0] {IDLE, ARB, WRITE} state_t;

    state_t           state, state_n;
    logic             vblank_d;
    logic [CNT_W-1:0] write_cnt;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    grant_idx;
    logic             grant_ok;
    logic             vblank_rise;
    logic             budget_ok;
    int               rr_idx;

    assign vblank_rise = vblank & ~vblank_d;
    // The counter clears on the rise edge itself, so the window opens that same cycle.
    assign budget_ok   = vblank_rise | (write_cnt < BUDGET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        grant_ok  = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_ok && rq.req[rr_idx]) begin
                grant_ok  = 1'b1;
                grant_idx = GW'(rr_idx);
            end
        end
        case (state)
            IDLE:    if (vblank && (|rq.req) && budget_ok) state_n = ARB;
            ARB:     state_n = (vblank && grant_ok) ? WRITE : IDLE;
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_d   <= 1'b0;
            write_cnt  <= '0;
            budget_hit <= 1'b0;
            last_grant <= GW'(NUM_REQ - 1);
            busy       <= 1'b0;
            bram_en    <= 1'b0;
            bram_we    <= 4'h0;
            bram_addr  <= 32'h0;
            bram_wdata <= 32'h0;
            rq.ack     <= '0;
        end else begin
            vblank_d   <= vblank;
            busy       <= (state_n != IDLE);
            bram_en    <= 1'b0;
            bram_we    <= 4'h0;
            bram_addr  <= 32'h0;
            bram_wdata <= 32'h0;
            rq.ack     <= '0;
            if (state == ARB && state_n == WRITE) begin
                bram_en    <= 1'b1;
                bram_we    <= 4'hF;
                bram_addr  <= 32'(rq.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W]);
                bram_wdata <= 32'(rq.req_data[int'(grant_idx)*DATA_W +: DATA_W]);
                rq.ack     <= NUM_REQ'(1) << grant_idx;
                last_grant <= grant_idx;
            end
            // A new frame's reset of the count wins over a write finishing in the same cycle.
            if (vblank_rise) begin
                write_cnt  <= '0;
                budget_hit <= 1'b0;
            end else if (state == WRITE && write_cnt < BUDGET) begin
                write_cnt <= write_cnt + CNT_W'(1);
                if ((write_cnt + CNT_W'(1)) == BUDGET) budget_hit <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gram_write_arbiter.sv
// tb/tb_gram_write_arbiter.sv - scoreboard bench for gram_write_arbiter with FRAME_BUDGET=4
module tb_gram_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic [31:0] bram_addr, bram_wdata;
    logic [3:0]  bram_we;
    logic        bram_en, busy, budget_hit;
    int          cyc = 0;
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          mon_writes = 0;

    typedef struct {
        int          c;
        logic [2:0]  a;
        logic [11:0] ad;
        logic [15:0] d;
    } exp_t;
    exp_t exp_q[$];

    gram_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(16)) rq ();

    gram_write_arbiter #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(16), .FRAME_BUDGET(4)) dut (
        .clk(clk), .rst(rst), .vblank(vblank), .rq(rq),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
        .bram_en(bram_en), .busy(busy), .budget_hit(budget_hit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_en || (|rq.ack) || bram_we != 4'h0) begin
            exp_t e;
            vec_cnt++;
            mon_writes++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_write cyc=%0d ack=%b addr=%h wdata=%h we=%h", cyc, rq.ack, bram_addr, bram_wdata, bram_we);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.c || rq.ack !== e.a || bram_addr !== {20'h0, e.ad} || bram_wdata !== {16'h0, e.d}
                    || bram_we !== 4'hF || bram_en !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL write got cyc=%0d ack=%b addr=%h wdata=%h we=%h en=%b required cyc=%0d ack=%b addr=%h wdata=%h",
                             cyc, rq.ack, bram_addr, bram_wdata, bram_we, bram_en, e.c, e.a, e.ad, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [2:0] a, input logic [11:0] ad, input logic [15:0] d);
        exp_t e;
        e.c = c; e.a = a; e.ad = ad; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [11:0] ad, input logic [15:0] d);
        rq.req_addr[i*12 +: 12] = ad;
        rq.req_data[i*16 +: 16] = d;
    endtask

    initial begin
        int n, m, p, q, r, s;
        rst = 1'b1;
        vblank = 1'b1;
        rq.req = 3'b111;
        rq.req_addr = '0;
        rq.req_data = '0;

        // reset holds everything quiet even with requests and vblank present
        goto(2);
        chk("rst_ack", 32'(rq.ack), 32'h0);
        chk("rst_en", 32'(bram_en), 32'h0);
        chk("rst_we", 32'(bram_we), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_budget_hit", 32'(budget_hit), 32'h0);
        rst = 1'b0;
        vblank = 1'b0;
        goto(103);
        chk("no_write_outside_vblank", 32'(mon_writes), 32'd0);
        chk("idle_busy", 32'(busy), 32'h0);

        // single write, 2-cycle latency
        n = 105;
        goto(n);
        rq.req = 3'b001;
        set_req(0, 12'h123, 16'hBEEF);
        vblank = 1'b1;
        push(n + 2, 3'b001, 12'h123, 16'hBEEF);
        goto(n + 3);
        rq.req = 3'b000;
        goto(n + 6);
        chk("single_q_empty", 32'(exp_q.size()), 32'd0);

        rst = 1'b1;
        vblank = 1'b0;
        goto(n + 8);
        rst = 1'b0;

        // round robin with all requesters, budget of 4 writes
        n = n + 10;
        goto(n);
        set_req(0, 12'h100, 16'hA000);
        set_req(1, 12'h101, 16'hA001);
        set_req(2, 12'h102, 16'hA002);
        rq.req = 3'b111;
        vblank = 1'b1;
        push(n + 2,  3'b001, 12'h100, 16'hA000);
        push(n + 5,  3'b010, 12'h101, 16'hA001);
        push(n + 8,  3'b100, 12'h102, 16'hA002);
        push(n + 11, 3'b001, 12'h100, 16'hA010);
        goto(n + 3);  set_req(0, 12'h100, 16'hA010);
        goto(n + 6);  set_req(1, 12'h101, 16'hA011);
        goto(n + 9);  set_req(2, 12'h102, 16'hA012);
        goto(n + 11); chk("budget_not_yet", 32'(budget_hit), 32'h0);
        goto(n + 12); set_req(0, 12'h100, 16'hA020);
        goto(n + 13); chk("budget_hit_set", 32'(budget_hit), 32'h1);
        goto(n + 20);
        chk("budget_idle_busy", 32'(busy), 32'h0);
        chk("budget_hit_sticky", 32'(budget_hit), 32'h1);
        chk("budget_q_empty", 32'(exp_q.size()), 32'd0);
        vblank = 1'b0;

        m = n + 22;
        goto(m);
        vblank = 1'b1;
        push(m + 2, 3'b010, 12'h101, 16'hA011);
        push(m + 5, 3'b100, 12'h102, 16'hA012);
        goto(m + 1); chk("budget_hit_cleared", 32'(budget_hit), 32'h0);
        goto(m + 3); set_req(1, 12'h101, 16'hA021);
        goto(m + 6); set_req(2, 12'h102, 16'hA022);
        rq.req = 3'b000;
        goto(m + 10);
        chk("frame2_q_empty", 32'(exp_q.size()), 32'd0);

        // vblank falls during ARB: slot lost, request served after next rise
        p = m + 10;
        rq.req = 3'b001;
        set_req(0, 12'h055, 16'h5555);
        goto(p + 1);
        chk("arb_busy", 32'(busy), 32'h1);
        vblank = 1'b0;
        goto(p + 2);
        chk("arb_abort_busy", 32'(busy), 32'h0);
        chk("arb_abort_en", 32'(bram_en), 32'h0);
        q = p + 6;
        goto(q);
        vblank = 1'b1;
        push(q + 2, 3'b001, 12'h055, 16'h5555);
        goto(q + 3);
        rq.req = 3'b000;
        goto(q + 6);
        chk("abort_q_empty", 32'(exp_q.size()), 32'd0);

        // reset during WRITE drops the write; round robin restarts at 0
        r = q + 6;
        rq.req = 3'b010;
        set_req(1, 12'h0AA, 16'hAAAA);
        goto(r + 2);
        rst = 1'b1;
        #1;
        chk("rst_write_we", 32'(bram_we), 32'h0);
        chk("rst_write_ack", 32'(rq.ack), 32'h0);
        chk("rst_write_en", 32'(bram_en), 32'h0);
        rq.req = 3'b111;
        set_req(0, 12'h100, 16'hA000);
        s = r + 4;
        goto(s);
        rst = 1'b0;
        push(s + 2, 3'b001, 12'h100, 16'hA000);
        goto(s + 3);
        rq.req = 3'b000;
        goto(s + 8);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);
        chk("total_writes", 32'(mon_writes), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
